pipe_hazard_ctrl: RTL and testbench
===================================

Name: pipe_hazard_ctrl

Overview:
- Central stall/flush sequencer for the 5-stage pipeline.
- Drives write-enable and flush controls of PC, IF/ID, ID/EX, EX/MEM and MEM/WB registers.
- Resolves load-use hazards and taken-branch flushes.
- Sequences a multi-cycle req/ack data-memory access for the instruction held in EX/MEM, latching read data for MEM/WB capture.

Parameters:
- MEM_TIMEOUT, 16, max cycles in REQ awaiting dmem_ack_i before abort (range 2..255).
- CNT_W, 32, width of stall-cycle performance counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- idex_memread_i  in  1  instruction in ID/EX is a load.
- idex_rd_i  in  5  destination register of ID/EX instruction.
- ifid_rs1_i  in  5  source register 1 of IF/ID instruction.
- ifid_rs2_i  in  5  source register 2 of IF/ID instruction.
- branch_taken_i  in  1  EX-stage branch/jump resolved taken.
- exmem_memacc_i  in  1  instruction in EX/MEM reads or writes data memory.
- dmem_req_o  out  1  data-memory request, registered.
- dmem_ack_i  in  1  data-memory completion, single-cycle pulse.
- dmem_rdata_i  in  32  read data, valid with dmem_ack_i.
- mem_rdata_o  out  32  latched read data to MEM/WB MemData input.
- pc_we_o  out  1  PC write enable.
- ifid_we_o  out  1  IF/ID write enable.
- ifid_flush_o  out  1  IF/ID load bubble.
- idex_we_o  out  1  ID/EX write enable.
- idex_flush_o  out  1  ID/EX load bubble (control bits zero).
- exmem_we_o  out  1  EX/MEM write enable.
- memwb_we_o  out  1  MEM/WB write enable.
- mem_err_o  out  1  sticky timeout flag.
- stall_cnt_o  out  CNT_W  count of cycles with memwb_we_o=0.

Behaviour:
- Reset (async, rst_n=0):
  - State RUN; dmem_req_o=0; mem_rdata_o=0; mem_err_o=0; stall_cnt_o=0; wait counter 0.
  - Control outputs take their RUN values from current inputs.
- FSM states: RUN, REQ, DONE.
  - RUN: exmem_memacc_i=1 -> freeze (all *_we_o=0, flushes 0), next REQ. Otherwise normal operation below.
  - REQ: dmem_req_o=1, freeze all, wait counter increments.
    - dmem_ack_i=1 -> latch dmem_rdata_i into mem_rdata_o, next DONE.
    - Counter reaching MEM_TIMEOUT without ack -> mem_rdata_o=0, mem_err_o=1, next DONE.
    - dmem_req_o drops the cycle after ack/timeout.
  - DONE: one cycle, all *_we_o=1 so MEM/WB captures. Next RUN unconditionally; exmem_memacc_i in DONE never re-triggers.
- Normal RUN operation (exmem_memacc_i=0), priority high to low:
  - branch_taken_i=1: all we=1, ifid_flush_o=1, idex_flush_o=1. Load-use ignored (flushed instruction).
  - Load-use, i.e. idex_memread_i=1 and idex_rd_i!=0 and idex_rd_i equals ifid_rs1_i or ifid_rs2_i: pc_we_o=0, ifid_we_o=0, idex_flush_o=1, exmem/memwb we=1.
  - Else: all we=1, flushes 0.
- Branch, load-use and DONE in same cycle: DONE enables win; branch and load-use flush/stall rules still apply.
- Branch or load-use while in REQ: suppressed; pipeline is frozen, so the condition re-evaluates in DONE/RUN.
- DONE and RUN outputs are combinational from state and inputs. dmem_req_o, mem_rdata_o and mem_err_o are registered.
- stall_cnt_o increments every cycle memwb_we_o=0 and saturates at all-ones.
- mem_err_o clears only on reset.
- Reset mid-REQ: dmem_req_o drops asynchronously; memory side must tolerate an abandoned request.

Decomposition:
- Shared package: state encoding (RUN=2'd0, REQ=2'd1, DONE=2'd2), register index width 5, data width 32.
- One natural sub-module, hazard_detect: combinational load-use compare.
- FSM, counters and latch stay in the top.

Test Plan:
- Load-use: idex_memread_i=1, idex_rd_i=5, ifid_rs2_i=5 -> pc_we_o=0, ifid_we_o=0, idex_flush_o=1 for exactly 1 cycle; repeat with idex_rd_i=0 -> no stall.
- Branch: branch_taken_i=1 together with the load-use condition -> ifid_flush_o=1, idex_flush_o=1, pc_we_o=1.
- Memory access: exmem_memacc_i=1, ack after 3 REQ cycles with rdata 0x1234ABCD:
  - freeze for 4 cycles (1 RUN + 3 REQ), then DONE with memwb_we_o=1 and mem_rdata_o=0x1234ABCD.
  - stall_cnt_o=4.
- Timeout: MEM_TIMEOUT=4, no ack -> dmem_req_o high 4 cycles then low; mem_err_o=1; mem_rdata_o=0; pipeline resumes through DONE.
- Branch during REQ: branch_taken_i held high -> no flush while in REQ; flushes appear in DONE.
- Reset mid-REQ: rst_n low at REQ cycle 2 -> dmem_req_o=0 immediately; state RUN, counters and mem_err_o 0 after release.

Source files
------------

// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared types and widths for the pipeline hazard / data-memory sequencer.
// Imported by the top and the load-use compare sub-module.
package pipe_hazard_ctrl_pkg;

  localparam int REG_W  = 5;
  localparam int DATA_W = 32;

  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_REQ  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/pipe_hazard_ctrl_hazard_detect.sv
// Load-use compare: a load in ID/EX whose destination feeds the IF/ID instruction.
// Register x0 never creates a dependency.
module pipe_hazard_ctrl_hazard_detect
  import pipe_hazard_ctrl_pkg::*;
(
  input  logic             memRead,
  input  logic [REG_W-1:0] idexRd,
  input  logic [REG_W-1:0] ifidRs1,
  input  logic [REG_W-1:0] ifidRs2,
  output logic             loadUse
);

  always_comb begin
    loadUse = memRead && (idexRd != '0) &&
              ((idexRd == ifidRs1) || (idexRd == ifidRs2));
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use stalls, taken-branch
// flushes and a req/ack data-memory access that freezes the pipe until done.
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              idex_memread_i,
  input  logic [REG_W-1:0]  idex_rd_i,
  input  logic [REG_W-1:0]  ifid_rs1_i,
  input  logic [REG_W-1:0]  ifid_rs2_i,
  input  logic              branch_taken_i,
  input  logic              exmem_memacc_i,
  output logic              dmem_req_o,
  input  logic              dmem_ack_i,
  input  logic [DATA_W-1:0] dmem_rdata_i,
  output logic [DATA_W-1:0] mem_rdata_o,
  output logic              pc_we_o,
  output logic              ifid_we_o,
  output logic              ifid_flush_o,
  output logic              idex_we_o,
  output logic              idex_flush_o,
  output logic              exmem_we_o,
  output logic              memwb_we_o,
  output logic              mem_err_o,
  output logic [CNT_W-1:0]  stall_cnt_o
);

  localparam logic [7:0] WAIT_LAST = 8'(MEM_TIMEOUT - 1);

  state_e     state;
  logic [7:0] waitCnt;
  logic       loadUse;
  logic       freeze;

  pipe_hazard_ctrl_hazard_detect uHazard (
    .memRead (idex_memread_i),
    .idexRd  (idex_rd_i),
    .ifidRs1 (ifid_rs1_i),
    .ifidRs2 (ifid_rs2_i),
    .loadUse (loadUse)
  );

  // The whole pipe holds while a memory access is being launched or is in flight.
  assign freeze = (state == ST_REQ) || ((state == ST_RUN) && exmem_memacc_i);

  // DONE shares the RUN hazard rules: EX/MEM and MEM/WB always capture there,
  // while a load-use still holds PC and IF/ID so the dependent instruction is kept.
  always_comb begin
    pc_we_o      = 1'b1;
    ifid_we_o    = 1'b1;
    idex_we_o    = 1'b1;
    exmem_we_o   = 1'b1;
    memwb_we_o   = 1'b1;
    ifid_flush_o = 1'b0;
    idex_flush_o = 1'b0;
    if (freeze) begin
      pc_we_o    = 1'b0;
      ifid_we_o  = 1'b0;
      idex_we_o  = 1'b0;
      exmem_we_o = 1'b0;
      memwb_we_o = 1'b0;
    end else if (branch_taken_i) begin
      ifid_flush_o = 1'b1;
      idex_flush_o = 1'b1;
    end else if (loadUse) begin
      pc_we_o      = 1'b0;
      ifid_we_o    = 1'b0;
      idex_flush_o = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_RUN;
      dmem_req_o  <= 1'b0;
      mem_rdata_o <= '0;
      mem_err_o   <= 1'b0;
      waitCnt     <= '0;
    end else begin
      case (state)
        ST_RUN: begin
          waitCnt <= '0;
          if (exmem_memacc_i) begin
            state      <= ST_REQ;
            dmem_req_o <= 1'b1;
          end
        end
        ST_REQ: begin
          if (dmem_ack_i) begin
            mem_rdata_o <= dmem_rdata_i;
            dmem_req_o  <= 1'b0;
            state       <= ST_DONE;
          end else if (waitCnt == WAIT_LAST) begin
            mem_rdata_o <= '0;
            mem_err_o   <= 1'b1;
            dmem_req_o  <= 1'b0;
            state       <= ST_DONE;
          end else begin
            waitCnt <= waitCnt + 8'd1;
          end
        end
        ST_DONE: begin
          waitCnt <= '0;
          state   <= ST_RUN;
        end
        default: begin
          dmem_req_o <= 1'b0;
          waitCnt    <= '0;
          state      <= ST_RUN;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_o <= '0;
    end else if (!memwb_we_o && (stall_cnt_o != '1)) begin
      stall_cnt_o <= stall_cnt_o + 1'b1;
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: directed scenarios plus randomized cycles,
// all compared against a transaction-level reference model.
module tb_pipe_hazard_ctrl;

  localparam int TMO   = 4;
  localparam int CNT_W = 32;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        idex_memread_i = 1'b0;
  logic [4:0]  idex_rd_i = '0, ifid_rs1_i = '0, ifid_rs2_i = '0;
  logic        branch_taken_i = 1'b0, exmem_memacc_i = 1'b0;
  logic        dmem_req_o, dmem_ack_i = 1'b0;
  logic [31:0] dmem_rdata_i = '0, mem_rdata_o;
  logic        pc_we_o, ifid_we_o, ifid_flush_o, idex_we_o, idex_flush_o;
  logic        exmem_we_o, memwb_we_o, mem_err_o;
  logic [CNT_W-1:0] stall_cnt_o;

  int nTests = 0;
  int nFail  = 0;

  pipe_hazard_ctrl #(.MEM_TIMEOUT(TMO), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .idex_memread_i(idex_memread_i), .idex_rd_i(idex_rd_i),
    .ifid_rs1_i(ifid_rs1_i), .ifid_rs2_i(ifid_rs2_i),
    .branch_taken_i(branch_taken_i), .exmem_memacc_i(exmem_memacc_i),
    .dmem_req_o(dmem_req_o), .dmem_ack_i(dmem_ack_i), .dmem_rdata_i(dmem_rdata_i),
    .mem_rdata_o(mem_rdata_o), .pc_we_o(pc_we_o), .ifid_we_o(ifid_we_o),
    .ifid_flush_o(ifid_flush_o), .idex_we_o(idex_we_o), .idex_flush_o(idex_flush_o),
    .exmem_we_o(exmem_we_o), .memwb_we_o(memwb_we_o), .mem_err_o(mem_err_o),
    .stall_cnt_o(stall_cnt_o)
  );

  always #5 clk = ~clk;

  // Reference model: an access is "in flight" for reqCycles cycles, then one
  // completion cycle; stall count is the number of cycles MEM/WB was held.
  bit          inReq, inDone;
  int          reqCycles;
  bit [31:0]   mRdata;
  bit          mErr;
  longint      mStall;
  bit          ePc, eIfid, eIfidFl, eIdex, eIdexFl, eExmem, eMemwb;

  function automatic void modelReset();
    inReq = 0; inDone = 0; reqCycles = 0; mRdata = '0; mErr = 0; mStall = 0;
  endfunction

  function automatic void modelOutputs();
    bit hold, lu;
    hold = inReq || (!inDone && exmem_memacc_i);
    lu = idex_memread_i && (idex_rd_i != 0) &&
         (idex_rd_i == ifid_rs1_i || idex_rd_i == ifid_rs2_i);
    {ePc, eIfid, eIdex, eExmem, eMemwb} = 5'b11111;
    {eIfidFl, eIdexFl} = 2'b00;
    if (hold) {ePc, eIfid, eIdex, eExmem, eMemwb} = 5'b00000;
    else if (branch_taken_i) {eIfidFl, eIdexFl} = 2'b11;
    else if (lu) begin ePc = 0; eIfid = 0; eIdexFl = 1; end
  endfunction

  function automatic void modelAdvance();
    if (!eMemwb && mStall < 64'hFFFF_FFFF) mStall++;
    if (inReq) begin
      reqCycles++;
      if (dmem_ack_i) begin mRdata = dmem_rdata_i; inReq = 0; inDone = 1; end
      else if (reqCycles == TMO) begin mRdata = '0; mErr = 1; inReq = 0; inDone = 1; end
    end else if (inDone) inDone = 0;
    else if (exmem_memacc_i) begin inReq = 1; reqCycles = 0; end
  endfunction

  task automatic checkVal(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nTests++;
    if (got !== exp) begin
      nFail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Apply one cycle of inputs at the falling edge and compare everything.
  task automatic drive(input logic rn, input logic mr, input logic [4:0] rd,
                       input logic [4:0] r1, input logic [4:0] r2, input logic br,
                       input logic ma, input logic ak, input logic [31:0] rdat);
    @(negedge clk);
    rst_n = rn; idex_memread_i = mr; idex_rd_i = rd; ifid_rs1_i = r1; ifid_rs2_i = r2;
    branch_taken_i = br; exmem_memacc_i = ma; dmem_ack_i = ak; dmem_rdata_i = rdat;
    if (!rn) modelReset();
    #1;
    modelOutputs();
    checkVal("pc_we", pc_we_o, ePc);
    checkVal("ifid_we", ifid_we_o, eIfid);
    checkVal("ifid_flush", ifid_flush_o, eIfidFl);
    checkVal("idex_we", idex_we_o, eIdex);
    checkVal("idex_flush", idex_flush_o, eIdexFl);
    checkVal("exmem_we", exmem_we_o, eExmem);
    checkVal("memwb_we", memwb_we_o, eMemwb);
    checkVal("dmem_req", dmem_req_o, inReq);
    checkVal("mem_rdata", mem_rdata_o, mRdata);
    checkVal("mem_err", mem_err_o, mErr);
    checkVal("stall_cnt", stall_cnt_o, mStall);
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst_n) modelAdvance();
  endtask

  task automatic idle(input logic ma, input logic br, input logic ak, input logic [31:0] rdat);
    drive(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, br, ma, ak, rdat);
  endtask

  task automatic doReset();
    drive(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 32'h0);
    checkVal("rst_stall_cnt", stall_cnt_o, 0);
    checkVal("rst_dmem_req", dmem_req_o, 0);
    tick();
  endtask

  initial begin
    modelReset();
    doReset();

    // Load-use on rs2, then the same with rd=x0.
    drive(1, 1, 5'd5, 5'd1, 5'd5, 0, 0, 0, 0);
    checkVal("lu_pc_we", pc_we_o, 0);
    checkVal("lu_idex_flush", idex_flush_o, 1);
    tick();
    drive(1, 0, 5'd5, 5'd1, 5'd5, 0, 0, 0, 0);
    checkVal("lu_released", pc_we_o, 1);
    tick();
    drive(1, 1, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0);
    checkVal("lu_x0_pc_we", pc_we_o, 1);
    tick();

    // Branch together with a load-use.
    drive(1, 1, 5'd5, 5'd5, 5'd2, 1, 0, 0, 0);
    checkVal("br_ifid_flush", ifid_flush_o, 1);
    checkVal("br_pc_we", pc_we_o, 1);
    tick();

    // Memory access acked on the 3rd request cycle.
    doReset();
    idle(1, 0, 0, 0); tick();
    idle(1, 0, 0, 0); tick();
    idle(1, 0, 0, 0); tick();
    idle(1, 0, 1, 32'h1234ABCD); tick();
    idle(1, 0, 0, 0);
    checkVal("acc_done_memwb_we", memwb_we_o, 1);
    checkVal("acc_rdata", mem_rdata_o, 32'h1234ABCD);
    checkVal("acc_stall_cnt", stall_cnt_o, 4);
    tick();
    idle(0, 0, 0, 0); tick();

    // Timeout with no ack.
    doReset();
    idle(1, 0, 0, 0); tick();
    for (int i = 0; i < TMO; i++) begin
      idle(0, 0, 0, 32'hDEAD0000);
      checkVal("tmo_req_high", dmem_req_o, 1);
      tick();
    end
    idle(0, 0, 0, 0);
    checkVal("tmo_req_low", dmem_req_o, 0);
    checkVal("tmo_err", mem_err_o, 1);
    checkVal("tmo_rdata", mem_rdata_o, 0);
    checkVal("tmo_done_memwb_we", memwb_we_o, 1);
    tick();

    // Branch held high across an access.
    doReset();
    idle(1, 1, 0, 0); tick();
    idle(0, 1, 0, 0);
    checkVal("brreq_no_flush", ifid_flush_o, 0);
    tick();
    idle(0, 1, 1, 32'h55); tick();
    idle(0, 1, 0, 0);
    checkVal("brreq_done_flush", ifid_flush_o, 1);
    tick();

    // Reset in the 2nd request cycle.
    doReset();
    idle(1, 0, 0, 0); tick();
    idle(0, 0, 0, 0); tick();
    drive(0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0);
    checkVal("midrst_req", dmem_req_o, 0);
    tick();
    idle(0, 0, 0, 0);
    checkVal("midrst_stall", stall_cnt_o, 0);
    checkVal("midrst_err", mem_err_o, 0);
    tick();

    // Randomized traffic; small register range to make hazards frequent.
    for (int c = 0; c < 3000; c++) begin
      drive(($urandom_range(0, 199) != 0), 1'($urandom), 5'($urandom_range(0, 3)),
            5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
            ($urandom_range(0, 3) == 0), ($urandom_range(0, 5) == 0),
            ($urandom_range(0, 3) == 0), $urandom);
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule
